// File: rtl/vid_tile_fetch_if.sv
// Map RAM read bus plus the tile/attribute bundle sent on to the character RAM.
interface vid_tile_fetch_if;
    logic [10:0] map_addr_0;
    logic [15:0] map_rdata_1;
    logic [6:0]  vp_char_2;
    logic [2:0]  vp_x_2;
    logic [2:0]  vp_y_2;
    logic        vp_mx_2;
    logic        vp_my_2;
    logic        vp_rot_2;
    logic        vp_dbl_2;
    logic [3:0]  vp_pal_5;
    logic        vp_active_5;

    modport master (
        output map_addr_0,
        input  map_rdata_1,
        output vp_char_2, vp_x_2, vp_y_2, vp_mx_2, vp_my_2, vp_rot_2, vp_dbl_2,
        output vp_pal_5, vp_active_5
    );

    modport slave (
        input  map_addr_0,
        output map_rdata_1,
        input  vp_char_2, vp_x_2, vp_y_2, vp_mx_2, vp_my_2, vp_rot_2, vp_dbl_2,
        input  vp_pal_5, vp_active_5
    );
endinterface

// File: rtl/vid_tile_fetch.sv
// Walks the scrolled 64x32 tile map, fetches one map entry per pixel and hands
// char/attributes to the character RAM; palette and active trail to stage 5.
module vid_tile_fetch (
    input  logic             vp_clk,
    input  logic             vp_rst_n,
    input  logic             vp_frame_0,
    input  logic             vp_line_0,
    input  logic             vp_active_0,
    input  logic             cfg_en,
    input  logic [8:0]       cfg_scroll_x,
    input  logic [7:0]       cfg_scroll_y,
    vid_tile_fetch_if.master vp
);
    logic [8:0]      px, sx;
    logic [7:0]      py, sy;
    logic [2:0]      x_lo, y_lo;
    logic [5:1]      vld_pipe;
    logic [5:2][3:0] pal_pipe;
    logic            unused_bits;

    // Bit 11 is reserved; sy is held only as the latched frame scroll copy.
    assign unused_bits = ^{vp.map_rdata_1[11], sy};

    assign vp.map_addr_0  = {py[7:3], px[8:3]};
    assign vp.vp_pal_5    = pal_pipe[5];
    assign vp.vp_active_5 = vld_pipe[5];

    always_ff @(posedge vp_clk) begin
        if (!vp_rst_n) begin
            px           <= '0;
            py           <= '0;
            sx           <= '0;
            sy           <= '0;
            x_lo         <= '0;
            y_lo         <= '0;
            vld_pipe     <= '0;
            pal_pipe     <= '0;
            vp.vp_char_2 <= '0;
            vp.vp_x_2    <= '0;
            vp.vp_y_2    <= '0;
            vp.vp_mx_2   <= 1'b0;
            vp.vp_my_2   <= 1'b0;
            vp.vp_rot_2  <= 1'b0;
            vp.vp_dbl_2  <= 1'b0;
        end else begin
            // Frame beats line beats pixel; a shadowed event is simply lost.
            if (vp_frame_0) begin
                sx <= cfg_scroll_x;
                sy <= cfg_scroll_y;
                px <= cfg_scroll_x;
                py <= cfg_scroll_y;
            end else if (vp_line_0) begin
                px <= sx;
                py <= py + 8'd1;
            end else if (vp_active_0) begin
                px <= px + 9'd1;
            end

            x_lo     <= px[2:0];
            y_lo     <= py[2:0];
            vld_pipe <= {vld_pipe[4:1], vp_active_0 & cfg_en};

            if (vld_pipe[1]) begin
                vp.vp_char_2 <= vp.map_rdata_1[6:0];
                vp.vp_mx_2   <= vp.map_rdata_1[7];
                vp.vp_my_2   <= vp.map_rdata_1[8];
                vp.vp_rot_2  <= vp.map_rdata_1[9];
                vp.vp_dbl_2  <= vp.map_rdata_1[10];
                vp.vp_x_2    <= x_lo;
                vp.vp_y_2    <= y_lo;
                pal_pipe[2]  <= vp.map_rdata_1[15:12];
            end else begin
                vp.vp_char_2 <= '0;
                vp.vp_mx_2   <= 1'b0;
                vp.vp_my_2   <= 1'b0;
                vp.vp_rot_2  <= 1'b0;
                vp.vp_dbl_2  <= 1'b0;
                vp.vp_x_2    <= '0;
                vp.vp_y_2    <= '0;
                pal_pipe[2]  <= '0;
            end
            pal_pipe[5:3] <= pal_pipe[4:2];
        end
    end
endmodule

// File: tb/tb_vid_tile_fetch.sv
// Directed bench for vid_tile_fetch with a 1-cycle map RAM model.
module tb_vid_tile_fetch;
    logic       vp_clk = 1'b0;
    logic       vp_rst_n = 1'b0;
    logic       vp_frame_0 = 1'b0;
    logic       vp_line_0 = 1'b0;
    logic       vp_active_0 = 1'b0;
    logic       cfg_en = 1'b0;
    logic [8:0] cfg_scroll_x = '0;
    logic [7:0] cfg_scroll_y = '0;
    logic       map_mode = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    vid_tile_fetch_if vp ();

    vid_tile_fetch dut (
        .vp_clk       (vp_clk),
        .vp_rst_n     (vp_rst_n),
        .vp_frame_0   (vp_frame_0),
        .vp_line_0    (vp_line_0),
        .vp_active_0  (vp_active_0),
        .cfg_en       (cfg_en),
        .cfg_scroll_x (cfg_scroll_x),
        .cfg_scroll_y (cfg_scroll_y),
        .vp           (vp)
    );

    always #5 vp_clk = ~vp_clk;

    // Map RAM: registered read, entry = 0x5000|addr or a fixed all-attribute entry.
    always @(posedge vp_clk)
        vp.map_rdata_1 <= map_mode ? 16'h07FF : (16'h5000 | {5'd0, vp.map_addr_0});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vp_clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] ch, input logic [2:0] x,
                                       input logic [2:0] y, input logic [3:0] at);
        return {15'd0, ch, x, y, at};
    endfunction

    function automatic logic [31:0] s2();
        return {15'd0, vp.vp_char_2, vp.vp_x_2, vp.vp_y_2,
                vp.vp_mx_2, vp.vp_my_2, vp.vp_rot_2, vp.vp_dbl_2};
    endfunction

    initial begin
        // Reset with random inputs
        for (int c = 0; c < 3; c++) begin
            vp_frame_0   = 1'($urandom);
            vp_line_0    = 1'($urandom);
            vp_active_0  = 1'($urandom);
            cfg_en       = 1'($urandom);
            cfg_scroll_x = 9'($urandom);
            cfg_scroll_y = 8'($urandom);
            tick();
            chk("rst_addr", 32'(vp.map_addr_0), 32'h0);
            chk("rst_s2", s2(), 32'h0);
            chk("rst_out5", {27'd0, vp.vp_pal_5, vp.vp_active_5}, 32'h0);
        end

        // Release: counters stay at 0 until a pulse, pixels still count
        vp_rst_n = 1'b1; vp_frame_0 = 0; vp_line_0 = 0; cfg_en = 1;
        for (int c = 0; c < 6; c++) begin
            vp_active_0 = (c < 4);
            if (c < 4) chk("rel_addr", 32'(vp.map_addr_0), 32'h0);
            if (c >= 2) chk("rel_x", 32'(vp.vp_x_2), 32'(c - 2));
            tick();
        end

        // Basic fetch
        cfg_scroll_x = 9'd0; cfg_scroll_y = 8'd0; vp_active_0 = 0;
        vp_frame_0 = 1; tick(); vp_frame_0 = 0;
        for (int c = 0; c < 21; c++) begin
            vp_active_0 = (c < 16);
            if (c < 16) chk("bas_addr", 32'(vp.map_addr_0), (c < 8) ? 32'h0 : 32'h1);
            if (c >= 2 && c < 18)
                chk("bas_s2", s2(), mk((c - 2 < 8) ? 7'h0 : 7'h1, 3'((c - 2) % 8), 3'd0, 4'h0));
            if (c >= 5) chk("bas_out5", {27'd0, vp.vp_pal_5, vp.vp_active_5}, {27'd0, 4'h5, 1'b1});
            tick();
        end

        // Scroll and wrap
        cfg_scroll_x = 9'd509; cfg_scroll_y = 8'd255; vp_active_0 = 0;
        vp_frame_0 = 1; tick(); vp_frame_0 = 0;
        for (int c = 0; c < 7; c++) begin
            vp_active_0 = (c < 5);
            if (c < 5) chk("wrap_addr", 32'(vp.map_addr_0), (c < 3) ? 32'h7FF : 32'h7C0);
            if (c >= 2) chk("wrap_xy", {26'd0, vp.vp_x_2, vp.vp_y_2}, {26'd0, 3'((c + 3) % 8), 3'd7});
            tick();
        end
        vp_line_0 = 1; tick(); vp_line_0 = 0;
        chk("wrap_line_addr", 32'(vp.map_addr_0), 32'h03F);

        // Attributes
        map_mode = 1; cfg_scroll_x = 0; cfg_scroll_y = 0;
        vp_frame_0 = 1; tick(); vp_frame_0 = 0;
        vp_active_0 = 1; tick(); vp_active_0 = 0; tick();
        chk("attr_s2", s2(), mk(7'h7F, 3'd0, 3'd0, 4'hF));
        tick(); tick(); tick();
        chk("attr_out5", {27'd0, vp.vp_pal_5, vp.vp_active_5}, {27'd0, 4'h0, 1'b1});
        cfg_en = 0; vp_active_0 = 1; tick(); vp_active_0 = 0; tick();
        chk("dis_s2", s2(), 32'h0);
        tick(); tick(); tick();
        chk("dis_out5", {27'd0, vp.vp_pal_5, vp.vp_active_5}, 32'h0);
        cfg_en = 1; map_mode = 0;

        // Coincident events
        cfg_scroll_x = 9'd16; cfg_scroll_y = 8'd8;
        vp_frame_0 = 1; vp_line_0 = 1; vp_active_0 = 1; tick();
        vp_frame_0 = 0; vp_line_0 = 0;
        chk("sim_addr", 32'(vp.map_addr_0), 32'h042);
        tick();
        vp_line_0 = 1; tick(); vp_line_0 = 0;
        chk("sim_line_addr", 32'(vp.map_addr_0), 32'h042);
        chk("sim_fr_xy", {26'd0, vp.vp_x_2, vp.vp_y_2}, {26'd0, 3'd0, 3'd0});
        tick();
        vp_active_0 = 0; tick();
        chk("sim_ln_xy", {26'd0, vp.vp_x_2, vp.vp_y_2}, {26'd0, 3'd0, 3'd1});

        // Scroll latching
        cfg_scroll_x = 9'd100;
        vp_active_0 = 1; tick(); tick(); vp_active_0 = 0;
        vp_line_0 = 1; tick(); vp_line_0 = 0;
        chk("lat_old_addr", 32'(vp.map_addr_0), 32'h042);
        vp_frame_0 = 1; tick(); vp_frame_0 = 0;
        chk("lat_new_addr", 32'(vp.map_addr_0), 32'h04C);
        vp_active_0 = 1; tick(); vp_active_0 = 0; tick();
        chk("lat_new_x", 32'(vp.vp_x_2), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
